// File: rtl/stopwatch_laps_pkg.sv
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared time record, FSM state encoding and field limits for
//               the stopwatch_laps core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

    localparam int CENT_MAX = 99;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;

    typedef struct packed {
        logic [5:0] min;
        logic [5:0] sec;
        logic [6:0] cent;
    } time_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } sw_state_e;

    function automatic logic time_is_max(input time_t t);
        return (t.cent == 7'(CENT_MAX)) && (t.sec == 6'(SEC_MAX)) &&
               (t.min == 6'(MIN_MAX));
    endfunction

    // Ripple carry cent -> sec -> min; 59:59.99 rolls to zero.
    function automatic time_t time_inc(input time_t t);
        time_t r;
        r = t;
        if (t.cent == 7'(CENT_MAX)) begin
            r.cent = '0;
            if (t.sec == 6'(SEC_MAX)) begin
                r.sec = '0;
                if (t.min == 6'(MIN_MAX)) begin
                    r.min = '0;
                end else begin
                    r.min = t.min + 6'd1;
                end
            end else begin
                r.sec = t.sec + 6'd1;
            end
        end else begin
            r.cent = t.cent + 7'd1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stopwatch_laps_buffer.sv
// ============================================================================
// Module      : lap_buffer
// Description : Circular lap store indexed relative to the oldest entry.
//               Macro LAP_OVERWRITE_EN selects overwrite-oldest when full;
//               otherwise laps are dropped once full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lap_buffer
    import stopwatch_pkg::*;
#(
    parameter int  LAP_DEPTH = 4,
    localparam int IW        = $clog2(LAP_DEPTH),
    localparam int CW        = $clog2(LAP_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          wr_i,
    input  time_t         wr_data_i,
    input  logic [IW-1:0] rd_idx_i,
    output time_t         rd_data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o
);

    time_t         mem_q [LAP_DEPTH];
    logic [IW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          w_full;
    logic          w_accept;
    logic          w_rd_valid;
    logic [IW-1:0] w_base;
    logic [IW:0]   w_sum;
    logic [IW:0]   w_phys;

    assign w_full = (count_q == CW'(LAP_DEPTH));

`ifdef LAP_OVERWRITE_EN
    assign w_accept = wr_i && !clr_i;
`else
    assign w_accept = wr_i && !clr_i && !w_full;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (w_accept) begin
            wr_ptr_d = (wr_ptr_q == IW'(LAP_DEPTH - 1)) ? '0 : wr_ptr_q + IW'(1);
            if (!w_full) begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Once full the write pointer sits on the oldest entry.
    assign w_base     = w_full ? wr_ptr_q : '0;
    assign w_sum      = {1'b0, w_base} + {1'b0, rd_idx_i};
    assign w_phys     = (w_sum >= (IW+1)'(LAP_DEPTH)) ? w_sum - (IW+1)'(LAP_DEPTH) : w_sum;
    assign w_rd_valid = ({1'b0, rd_idx_i} < (IW+1)'(count_q));

    assign rd_data_o = w_rd_valid ? mem_q[w_phys[IW-1:0]] : '0;
    assign count_o   = count_q;
    assign full_o    = w_full;

endmodule

`default_nettype wire

// File: rtl/stopwatch_laps.sv
// ============================================================================
// Module      : stopwatch_laps
// Description : mm:ss.cc stopwatch with start/pause/clear FSM, prescaler and
//               lap buffer (overwrite policy via macro LAP_OVERWRITE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_laps
    import stopwatch_pkg::*;
#(
    parameter int  CLK_DIV   = 1,
    parameter int  LAP_DEPTH = 4,
    localparam int IW        = $clog2(LAP_DEPTH),
    localparam int CW        = $clog2(LAP_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          pause_i,
    input  logic          clear_i,
    input  logic          lap_i,
    input  logic          show_lap_i,
    input  logic [IW-1:0] rd_idx_i,
    output logic [6:0]    cent_o,
    output logic [5:0]    sec_o,
    output logic [5:0]    min_o,
    output logic          running_o,
    output logic [CW-1:0] lap_count_o,
    output logic          lap_full_o,
    output logic          wrap_o
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    sw_state_e     state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    time_t         time_q,  time_d;
    time_t         disp_q,  disp_d;
    logic          wrap_q,  wrap_d;

    logic          w_tick;
    logic          w_lap_wr;
    time_t         w_lap_rd;

    assign w_tick   = (state_q == RUN) && (presc_q == PW'(CLK_DIV - 1));
    assign w_lap_wr = lap_i && !clear_i && (state_q != IDLE);

    lap_buffer #(
        .LAP_DEPTH (LAP_DEPTH)
    ) u_lap_buffer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (clear_i),
        .wr_i      (w_lap_wr),
        .wr_data_i (time_q),
        .rd_idx_i  (rd_idx_i),
        .rd_data_o (w_lap_rd),
        .count_o   (lap_count_o),
        .full_o    (lap_full_o)
    );

    // Pause outranks start, so a simultaneous start is dropped even when the
    // pause itself has no effect.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        time_d  = time_q;
        wrap_d  = 1'b0;
        if (clear_i) begin
            state_d = IDLE;
            presc_d = '0;
            time_d  = '0;
        end else begin
            if (state_q == RUN) begin
                presc_d = w_tick ? '0 : presc_q + PW'(1);
            end
            if (w_tick) begin
                time_d = time_inc(time_q);
                wrap_d = time_is_max(time_q);
            end
            if (pause_i) begin
                if (state_q == RUN) begin
                    state_d = PAUSED;
                end
            end else if (start_i && (state_q != RUN)) begin
                state_d = RUN;
            end
        end
    end

    // Invalid lap indices already read back as zero from the buffer.
    always_comb begin
        disp_d = show_lap_i ? w_lap_rd : time_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            time_q  <= '0;
            disp_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            time_q  <= time_d;
            disp_q  <= disp_d;
            wrap_q  <= wrap_d;
        end
    end

    assign cent_o    = disp_q.cent;
    assign sec_o     = disp_q.sec;
    assign min_o     = disp_q.min;
    assign running_o = (state_q == RUN);
    assign wrap_o    = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_laps.sv
// ============================================================================
// Module      : tb_stopwatch_laps
// Description : Self-checking bench for stopwatch_laps (CLK_DIV 1 and 4);
//               expectations follow macro LAP_OVERWRITE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_laps;

    localparam int DEPTH = 4;
    localparam int TMAX  = 360000;
`ifdef LAP_OVERWRITE_EN
    localparam bit OW = 1'b1;
`else
    localparam bit OW = 1'b0;
`endif

    logic       clk;
    logic       rst, start, pause, clear, lap, show;
    logic [1:0] rd;

    logic [6:0] cent_w [2];
    logic [5:0] sec_w  [2];
    logic [5:0] min_w  [2];
    logic       run_w  [2];
    logic [2:0] cnt_w  [2];
    logic       full_w [2];
    logic       wrap_w [2];

    int checks   = 0;
    int failures = 0;

    // Reference model: time as total centiseconds, laps as an oldest-first list.
    int divs  [2] = '{1, 4};
    int m_st  [2];
    int m_t   [2];
    int m_pre [2];
    int m_n   [2];
    int m_lap [2][DEPTH];
    int m_disp[2];
    int m_wrap[2];

    stopwatch_laps #(.CLK_DIV(1), .LAP_DEPTH(DEPTH)) u_d1 (
        .clk(clk), .rst(rst), .start_i(start), .pause_i(pause), .clear_i(clear),
        .lap_i(lap), .show_lap_i(show), .rd_idx_i(rd),
        .cent_o(cent_w[0]), .sec_o(sec_w[0]), .min_o(min_w[0]), .running_o(run_w[0]),
        .lap_count_o(cnt_w[0]), .lap_full_o(full_w[0]), .wrap_o(wrap_w[0])
    );

    stopwatch_laps #(.CLK_DIV(4), .LAP_DEPTH(DEPTH)) u_d4 (
        .clk(clk), .rst(rst), .start_i(start), .pause_i(pause), .clear_i(clear),
        .lap_i(lap), .show_lap_i(show), .rd_idx_i(rd),
        .cent_o(cent_w[1]), .sec_o(sec_w[1]), .min_o(min_w[1]), .running_o(run_w[1]),
        .lap_count_o(cnt_w[1]), .lap_full_o(full_w[1]), .wrap_o(wrap_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_step(input int k);
        int  nd;
        bit  tick;
        if (show) nd = (int'(rd) < m_n[k]) ? m_lap[k][int'(rd)] : 0;
        else      nd = m_t[k];
        if (rst) begin
            m_st[k] = 0; m_t[k] = 0; m_pre[k] = 0; m_n[k] = 0;
            m_disp[k] = 0; m_wrap[k] = 0;
            return;
        end
        m_disp[k] = nd;
        m_wrap[k] = 0;
        if (clear) begin
            m_st[k] = 0; m_t[k] = 0; m_pre[k] = 0; m_n[k] = 0;
            return;
        end
        tick = (m_st[k] == 1) && (m_pre[k] == divs[k] - 1);
        if (lap && m_st[k] != 0) begin
            if (m_n[k] < DEPTH) begin
                m_lap[k][m_n[k]] = m_t[k];
                m_n[k]++;
            end else if (OW) begin
                for (int i = 0; i < DEPTH - 1; i++) m_lap[k][i] = m_lap[k][i+1];
                m_lap[k][DEPTH-1] = m_t[k];
            end
        end
        if (m_st[k] == 1) m_pre[k] = tick ? 0 : m_pre[k] + 1;
        if (tick) begin
            m_wrap[k] = (m_t[k] == TMAX - 1) ? 1 : 0;
            m_t[k]    = (m_t[k] + 1) % TMAX;
        end
        if (pause) begin
            if (m_st[k] == 1) m_st[k] = 2;
        end else if (start && m_st[k] != 1) begin
            m_st[k] = 1;
        end
    endtask

    task automatic cmp_models();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d_cent", k), int'(cent_w[k]), m_disp[k] % 100);
            chk($sformatf("d%0d_sec",  k), int'(sec_w[k]),  (m_disp[k] / 100) % 60);
            chk($sformatf("d%0d_min",  k), int'(min_w[k]),  m_disp[k] / 6000);
            chk($sformatf("d%0d_running", k), int'(run_w[k]), (m_st[k] == 1) ? 1 : 0);
            chk($sformatf("d%0d_lap_count", k), int'(cnt_w[k]), m_n[k]);
            chk($sformatf("d%0d_lap_full", k), int'(full_w[k]), (m_n[k] == DEPTH) ? 1 : 0);
            chk($sformatf("d%0d_wrap", k), int'(wrap_w[k]), m_wrap[k]);
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic cyc(input int s, input int p, input int c, input int l,
                       input int sh, input int r);
        start = (s != 0); pause = (p != 0); clear = (c != 0); lap = (l != 0);
        show  = (sh != 0); rd = 2'(r);
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        cmp_models();
    endtask

    typedef struct {
        int s, p, c, l, sh, rd, n;
        int cent, sec, mins, run, cnt;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int exp_lap[DEPTH];

        tbl[0]  = '{1,0,0,0,0,0,101,  0,1,0, 1,0};
        tbl[1]  = '{0,1,0,0,0,0,2,    2,1,0, 0,0};
        tbl[2]  = '{0,0,0,1,1,0,1,    2,1,0, 0,1};
        tbl[3]  = '{1,0,0,0,0,0,3,    4,1,0, 1,1};
        tbl[4]  = '{0,0,0,1,1,1,1,    5,1,0, 1,2};
        tbl[5]  = '{0,0,0,0,1,3,1,    0,0,0, 1,2};
        tbl[6]  = '{0,0,1,1,0,0,1,    0,0,0, 0,0};
        tbl[7]  = '{0,0,0,1,0,0,1,    0,0,0, 0,0};
        tbl[8]  = '{1,0,0,0,0,0,38,  37,0,0, 1,0};
        tbl[9]  = '{0,1,0,0,0,0,50,  39,0,0, 0,0};
        tbl[10] = '{1,0,0,0,0,0,2,   40,0,0, 1,0};

        rst = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; lap = 1'b0;
        show = 1'b0; rd = 2'd0;
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_t[k] = 0; m_pre[k] = 0; m_n[k] = 0;
            m_disp[k] = 0; m_wrap[k] = 0;
        end
        @(negedge clk);
        cyc(0,0,0,0,0,0);
        cyc(0,0,0,0,0,0);
        chk("reset_cent", int'(cent_w[0]), 0);
        chk("reset_running", int'(run_w[0]), 0);
        chk("reset_lap_count", int'(cnt_w[0]), 0);
        rst = 1'b0;

        // Directed table against fixed expectations on the CLK_DIV=1 core.
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].l, tbl[i].sh, tbl[i].rd);
            repeat (tbl[i].n) cyc(0,0,0,0, tbl[i].sh, tbl[i].rd);
            chk($sformatf("tbl%0d_cent", i), int'(cent_w[0]), tbl[i].cent);
            chk($sformatf("tbl%0d_sec",  i), int'(sec_w[0]),  tbl[i].sec);
            chk($sformatf("tbl%0d_min",  i), int'(min_w[0]),  tbl[i].mins);
            chk($sformatf("tbl%0d_running", i), int'(run_w[0]), tbl[i].run);
            chk($sformatf("tbl%0d_lap_count", i), int'(cnt_w[0]), tbl[i].cnt);
        end

        // Lap coincident with a tick at 00:00.09 keeps the pre-tick time.
        cyc(0,0,1,0,0,0);
        cyc(1,0,0,0,0,0);
        repeat (9) cyc(0,0,0,0,0,0);
        cyc(0,0,0,1,1,0);
        cyc(0,0,0,0,1,0);
        chk("lap_tick_cent", int'(cent_w[0]), 9);

        // Five laps into a four-entry buffer.
        cyc(0,0,1,0,0,0);
        cyc(1,0,0,0,0,0);
        repeat (10) cyc(0,0,0,0,0,0);
        cyc(0,0,0,1,0,0);
        for (int j = 0; j < 4; j++) begin
            repeat (9) cyc(0,0,0,0,0,0);
            cyc(0,0,0,1,0,0);
        end
        cyc(0,1,0,0,0,0);
        chk("laps_full", int'(full_w[0]), 1);
        chk("laps_count", int'(cnt_w[0]), DEPTH);
        for (int r = 0; r < DEPTH; r++) exp_lap[r] = OW ? 20 + 10 * r : 10 + 10 * r;
        for (int r = 0; r < DEPTH; r++) begin
            cyc(0,0,0,0,1,r);
            cyc(0,0,0,0,1,r);
            chk($sformatf("lap_rd%0d_cent", r), int'(cent_w[0]), exp_lap[r]);
            chk($sformatf("lap_rd%0d_sec", r), int'(sec_w[0]), 0);
        end

        // Rollover from 59:59.99: time preloaded while paused.
        cyc(0,0,1,0,0,0);
        cyc(1,0,0,0,0,0);
        cyc(0,1,0,0,0,0);
        force u_d1.time_q = {6'd59, 6'd59, 7'd99};
        m_t[0] = TMAX - 1;
        cyc(0,0,0,0,0,0);
        cyc(0,0,0,0,0,0);
        release u_d1.time_q;
        cyc(1,0,0,0,0,0);
        cyc(0,0,0,0,0,0);
        chk("wrap_pulse", int'(wrap_w[0]), 1);
        chk("wrap_pre_min", int'(min_w[0]), 59);
        chk("wrap_pre_cent", int'(cent_w[0]), 99);
        cyc(0,0,0,0,0,0);
        chk("wrap_single", int'(wrap_w[0]), 0);
        chk("wrap_post_min", int'(min_w[0]), 0);
        chk("wrap_post_cent", int'(cent_w[0]), 0);

        // Reset in the middle of a run.
        cyc(0,0,1,0,0,0);
        cyc(1,0,0,0,0,0);
        repeat (7) cyc(0,0,0,1,0,0);
        rst = 1'b1;
        cyc(0,0,0,0,0,0);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_run_d%0d_cent", k), int'(cent_w[k]), 0);
            chk($sformatf("rst_run_d%0d_running", k), int'(run_w[k]), 0);
            chk($sformatf("rst_run_d%0d_lap_count", k), int'(cnt_w[k]), 0);
        end

        // Random traffic against the model on both prescaler settings.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            cyc(($urandom_range(0, 9) == 0) ? 1 : 0,
                ($urandom_range(0, 19) == 0) ? 1 : 0,
                ($urandom_range(0, 99) == 0) ? 1 : 0,
                ($urandom_range(0, 14) == 0) ? 1 : 0,
                int'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
